// File: rtl/cache_axi_pkg.sv
// Shared types and helpers for the cache-to-AXI bridge: FSM state encodings,
// the default line size and the line-address alignment function.
package cache_axi_pkg;

    localparam int LINE_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ICACHE = 2'd1,
        R_DCACHE = 2'd2,
        R_UNC    = 2'd3
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LINE = 2'd1,
        W_UNC  = 2'd2
    } wr_state_e;

    // Works on a 64-bit container so any address width up to 64 can share it.
    function automatic logic [63:0] line_addr(input logic [63:0] addr, input int unsigned offs_w);
        return (addr >> offs_w) << offs_w;
    endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Single-ID AXI-style master bus between the bridge (master) and the memory side (slave).
interface cache_axi_bridge_if #(
    parameter int ADDR_W = 32
);
    logic              axi_ren_o;
    logic [ADDR_W-1:0] axi_raddr_o;
    logic [7:0]        axi_rlen_o;
    logic [31:0]       rdata_i;
    logic              rdata_valid_i;
    logic              axi_wen_o;
    logic [ADDR_W-1:0] axi_waddr_o;
    logic [7:0]        axi_wlen_o;
    logic [3:0]        axi_wsel_o;
    logic [31:0]       axi_wdata_o;
    logic              axi_wlast_o;
    logic              wdata_resp_i;

    modport master (
        output axi_ren_o, axi_raddr_o, axi_rlen_o,
        output axi_wen_o, axi_waddr_o, axi_wlen_o, axi_wsel_o, axi_wdata_o, axi_wlast_o,
        input  rdata_i, rdata_valid_i, wdata_resp_i
    );

    modport slave (
        input  axi_ren_o, axi_raddr_o, axi_rlen_o,
        input  axi_wen_o, axi_waddr_o, axi_wlen_o, axi_wsel_o, axi_wdata_o, axi_wlast_o,
        output rdata_i, rdata_valid_i, wdata_resp_i
    );
endinterface

// File: rtl/cache_axi_rd_arb.sv
// Read-grant logic: uncached first, then cached fills masked by the writeback hazard.
// CACHE_AXI_RR_ARB_EN selects round-robin between dcache and icache fills.
module cache_axi_rd_arb (
`ifdef CACHE_AXI_RR_ARB_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic i_idle,
    input  logic i_unc_req,
    input  logic i_data_req,
    input  logic i_data_haz,
    input  logic i_inst_req,
    input  logic i_inst_haz,
    output logic o_gnt_unc,
    output logic o_gnt_data,
    output logic o_gnt_inst
);
    logic w_data_ok;
    logic w_inst_ok;

    assign w_data_ok = i_idle && i_data_req && !i_data_haz;
    assign w_inst_ok = i_idle && i_inst_req && !i_inst_haz;
    assign o_gnt_unc = i_idle && i_unc_req;

`ifdef CACHE_AXI_RR_ARB_EN
    logic r_last_inst;

    // Cached-fill pick: alternate when both are eligible, otherwise take whichever is.
    always_comb begin
        o_gnt_data = 1'b0;
        o_gnt_inst = 1'b0;
        if (o_gnt_unc) begin
            o_gnt_data = 1'b0;
            o_gnt_inst = 1'b0;
        end else if (w_data_ok && w_inst_ok) begin
            o_gnt_data = r_last_inst;
            o_gnt_inst = !r_last_inst;
        end else begin
            o_gnt_data = w_data_ok;
            o_gnt_inst = w_inst_ok;
        end
    end

    // Last-granted pointer; starts as if icache went last so dcache wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_inst <= 1'b1;
        end else if (o_gnt_data) begin
            r_last_inst <= 1'b0;
        end else if (o_gnt_inst) begin
            r_last_inst <= 1'b1;
        end else begin
            r_last_inst <= r_last_inst;
        end
    end
`else
    assign o_gnt_data = !o_gnt_unc && w_data_ok;
    assign o_gnt_inst = !o_gnt_unc && !w_data_ok && w_inst_ok;
`endif

endmodule

// File: rtl/cache_axi_bridge.sv
// Bridge from L1 icache/dcache fills, dcache writebacks and uncached accesses to one AXI master.
// Optional build macro CACHE_AXI_RR_ARB_EN: round-robin between icache and dcache fills.
module cache_axi_bridge
    import cache_axi_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32,
    parameter int OFFS_W     = $clog2(LINE_WORDS) + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_ren_i,
    input  logic [ADDR_W-1:0]      inst_araddr_i,
    output logic                   inst_rvalid_o,
    output logic [32*LINE_WORDS-1:0] inst_rdata_o,
    input  logic                   data_ren_i,
    input  logic [ADDR_W-1:0]      data_araddr_i,
    output logic                   data_rvalid_o,
    output logic [32*LINE_WORDS-1:0] data_rdata_o,
    input  logic                   data_wen_i,
    input  logic [ADDR_W-1:0]      data_awaddr_i,
    input  logic [32*LINE_WORDS-1:0] data_wdata_i,
    output logic                   data_bvalid_o,
    input  logic                   unc_ren_i,
    input  logic [ADDR_W-1:0]      unc_raddr_i,
    output logic                   unc_rvalid_o,
    output logic [31:0]            unc_rdata_o,
    input  logic [3:0]             unc_wen_i,
    input  logic [ADDR_W-1:0]      unc_waddr_i,
    input  logic [31:0]            unc_wdata_i,
    output logic                   unc_bvalid_o,
    output logic                   dev_rrdy_o,
    output logic                   dev_wrdy_o,
    cache_axi_bridge_if.master     axi
);
    localparam int               CNT_W    = $clog2(LINE_WORDS);
    localparam int               LINE_W   = 32 * LINE_WORDS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);
    localparam logic [7:0]       LEN_LINE = 8'(LINE_WORDS - 1);

    rd_state_e          r_rstate;
    logic [ADDR_W-1:0]  r_raddr;
    logic [7:0]         r_rlen;
    logic [CNT_W-1:0]   r_rcnt;
    logic [LINE_W-1:0]  r_inst_line;
    logic [LINE_W-1:0]  r_data_line;
    logic [31:0]        r_unc_rdata;
    logic               r_inst_rvalid;
    logic               r_data_rvalid;
    logic               r_unc_rvalid;

    wr_state_e          r_wstate;
    logic [ADDR_W-1:0]  r_waddr;
    logic [7:0]         r_wlen;
    logic [3:0]         r_wsel;
    logic [CNT_W-1:0]   r_wcnt;
    logic [LINE_W-1:0]  r_wline;
    logic               r_data_bvalid;
    logic               r_unc_bvalid;

    logic w_wline_busy;
    logic w_inst_haz;
    logic w_data_haz;
    logic w_gnt_unc;
    logic w_gnt_data;
    logic w_gnt_inst;

    // A fill must not overtake a writeback of the same line still draining to memory.
    assign w_wline_busy = (r_wstate == W_LINE);
    assign w_inst_haz   = w_wline_busy && (ADDR_W'(line_addr(64'(inst_araddr_i), OFFS_W)) == r_waddr);
    assign w_data_haz   = w_wline_busy && (ADDR_W'(line_addr(64'(data_araddr_i), OFFS_W)) == r_waddr);

    cache_axi_rd_arb u_rd_arb (
`ifdef CACHE_AXI_RR_ARB_EN
        .clk        (clk),
        .rst        (rst),
`endif
        .i_idle     (r_rstate == R_IDLE),
        .i_unc_req  (unc_ren_i),
        .i_data_req (data_ren_i),
        .i_data_haz (w_data_haz),
        .i_inst_req (inst_ren_i),
        .i_inst_haz (w_inst_haz),
        .o_gnt_unc  (w_gnt_unc),
        .o_gnt_data (w_gnt_data),
        .o_gnt_inst (w_gnt_inst)
    );

    // Read FSM: grant, beat collection into the per-requester line buffers, done pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate      <= R_IDLE;
            r_raddr       <= '0;
            r_rlen        <= 8'd0;
            r_rcnt        <= '0;
            r_inst_line   <= '0;
            r_data_line   <= '0;
            r_unc_rdata   <= 32'd0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            r_unc_rvalid  <= 1'b0;
        end else begin
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            r_unc_rvalid  <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    r_rcnt <= '0;
                    if (w_gnt_unc) begin
                        r_rstate <= R_UNC;
                        r_raddr  <= unc_raddr_i;
                        r_rlen   <= 8'd0;
                    end else if (w_gnt_data) begin
                        r_rstate <= R_DCACHE;
                        r_raddr  <= ADDR_W'(line_addr(64'(data_araddr_i), OFFS_W));
                        r_rlen   <= LEN_LINE;
                    end else if (w_gnt_inst) begin
                        r_rstate <= R_ICACHE;
                        r_raddr  <= ADDR_W'(line_addr(64'(inst_araddr_i), OFFS_W));
                        r_rlen   <= LEN_LINE;
                    end else begin
                        r_rstate <= R_IDLE;
                    end
                end
                R_ICACHE: begin
                    if (axi.rdata_valid_i) begin
                        r_inst_line[32*r_rcnt +: 32] <= axi.rdata_i;
                        if (r_rcnt == CNT_LAST) begin
                            r_rstate      <= R_IDLE;
                            r_inst_rvalid <= 1'b1;
                            r_rcnt        <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + CNT_W'(1);
                        end
                    end else begin
                        r_rstate <= R_ICACHE;
                    end
                end
                R_DCACHE: begin
                    if (axi.rdata_valid_i) begin
                        r_data_line[32*r_rcnt +: 32] <= axi.rdata_i;
                        if (r_rcnt == CNT_LAST) begin
                            r_rstate      <= R_IDLE;
                            r_data_rvalid <= 1'b1;
                            r_rcnt        <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + CNT_W'(1);
                        end
                    end else begin
                        r_rstate <= R_DCACHE;
                    end
                end
                R_UNC: begin
                    if (axi.rdata_valid_i) begin
                        r_unc_rdata  <= axi.rdata_i;
                        r_unc_rvalid <= 1'b1;
                        r_rstate     <= R_IDLE;
                    end else begin
                        r_rstate <= R_UNC;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Write FSM: everything is latched at acceptance so the requester may move on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate      <= W_IDLE;
            r_waddr       <= '0;
            r_wlen        <= 8'd0;
            r_wsel        <= 4'd0;
            r_wcnt        <= '0;
            r_wline       <= '0;
            r_data_bvalid <= 1'b0;
            r_unc_bvalid  <= 1'b0;
        end else begin
            r_data_bvalid <= 1'b0;
            r_unc_bvalid  <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    r_wcnt <= '0;
                    if (unc_wen_i != 4'd0) begin
                        r_wstate <= W_UNC;
                        r_waddr  <= unc_waddr_i;
                        r_wlen   <= 8'd0;
                        r_wsel   <= unc_wen_i;
                        r_wline  <= LINE_W'(unc_wdata_i);
                    end else if (data_wen_i) begin
                        r_wstate <= W_LINE;
                        r_waddr  <= ADDR_W'(line_addr(64'(data_awaddr_i), OFFS_W));
                        r_wlen   <= LEN_LINE;
                        r_wsel   <= 4'hF;
                        r_wline  <= data_wdata_i;
                    end else begin
                        r_wstate <= W_IDLE;
                    end
                end
                W_LINE: begin
                    if (axi.wdata_resp_i) begin
                        if (r_wcnt == CNT_LAST) begin
                            r_wstate      <= W_IDLE;
                            r_data_bvalid <= 1'b1;
                            r_wcnt        <= '0;
                        end else begin
                            r_wcnt <= r_wcnt + CNT_W'(1);
                        end
                    end else begin
                        r_wstate <= W_LINE;
                    end
                end
                W_UNC: begin
                    if (axi.wdata_resp_i) begin
                        r_wstate     <= W_IDLE;
                        r_unc_bvalid <= 1'b1;
                    end else begin
                        r_wstate <= W_UNC;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign inst_rvalid_o = r_inst_rvalid;
    assign inst_rdata_o  = r_inst_line;
    assign data_rvalid_o = r_data_rvalid;
    assign data_rdata_o  = r_data_line;
    assign unc_rvalid_o  = r_unc_rvalid;
    assign unc_rdata_o   = r_unc_rdata;
    assign data_bvalid_o = r_data_bvalid;
    assign unc_bvalid_o  = r_unc_bvalid;
    assign dev_rrdy_o    = (r_rstate == R_IDLE);
    assign dev_wrdy_o    = (r_wstate == W_IDLE);

    assign axi.axi_ren_o   = (r_rstate != R_IDLE);
    assign axi.axi_raddr_o = r_raddr;
    assign axi.axi_rlen_o  = r_rlen;
    assign axi.axi_wen_o   = (r_wstate != W_IDLE);
    assign axi.axi_waddr_o = r_waddr;
    assign axi.axi_wlen_o  = r_wlen;
    assign axi.axi_wsel_o  = r_wsel;
    assign axi.axi_wdata_o = r_wline[32*r_wcnt +: 32];
    assign axi.axi_wlast_o = (r_wstate == W_UNC) || ((r_wstate == W_LINE) && (r_wcnt == CNT_LAST));

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge with a 4-word line; the arbitration
// expectations follow the CACHE_AXI_RR_ARB_EN build macro.
module tb_cache_axi_bridge;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          inst_ren_i = 1'b0;
    logic [31:0]   inst_araddr_i = 32'd0;
    logic          inst_rvalid_o;
    logic [127:0]  inst_rdata_o;
    logic          data_ren_i = 1'b0;
    logic [31:0]   data_araddr_i = 32'd0;
    logic          data_rvalid_o;
    logic [127:0]  data_rdata_o;
    logic          data_wen_i = 1'b0;
    logic [31:0]   data_awaddr_i = 32'd0;
    logic [127:0]  data_wdata_i = 128'd0;
    logic          data_bvalid_o;
    logic          unc_ren_i = 1'b0;
    logic [31:0]   unc_raddr_i = 32'd0;
    logic          unc_rvalid_o;
    logic [31:0]   unc_rdata_o;
    logic [3:0]    unc_wen_i = 4'd0;
    logic [31:0]   unc_waddr_i = 32'd0;
    logic [31:0]   unc_wdata_i = 32'd0;
    logic          unc_bvalid_o;
    logic          dev_rrdy_o;
    logic          dev_wrdy_o;

    int n_total = 0;
    int n_bad   = 0;

    cache_axi_bridge_if #(.ADDR_W(32)) axi_bus ();

    cache_axi_bridge #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_ren_i    (inst_ren_i),
        .inst_araddr_i (inst_araddr_i),
        .inst_rvalid_o (inst_rvalid_o),
        .inst_rdata_o  (inst_rdata_o),
        .data_ren_i    (data_ren_i),
        .data_araddr_i (data_araddr_i),
        .data_rvalid_o (data_rvalid_o),
        .data_rdata_o  (data_rdata_o),
        .data_wen_i    (data_wen_i),
        .data_awaddr_i (data_awaddr_i),
        .data_wdata_i  (data_wdata_i),
        .data_bvalid_o (data_bvalid_o),
        .unc_ren_i     (unc_ren_i),
        .unc_raddr_i   (unc_raddr_i),
        .unc_rvalid_o  (unc_rvalid_o),
        .unc_rdata_o   (unc_rdata_o),
        .unc_wen_i     (unc_wen_i),
        .unc_waddr_i   (unc_waddr_i),
        .unc_wdata_i   (unc_wdata_i),
        .unc_bvalid_o  (unc_bvalid_o),
        .dev_rrdy_o    (dev_rrdy_o),
        .dev_wrdy_o    (dev_wrdy_o),
        .axi           (axi_bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the read FSM to leave idle.
    task automatic wait_ren();
        for (int i = 0; i < 20 && !axi_bus.axi_ren_o; i++) tick();
        check_val("grant_seen", {127'd0, axi_bus.axi_ren_o}, 128'd1);
    endtask

    // Deliver LW beats base, base+1, ... with no gaps.
    task automatic feed_line(input logic [31:0] base);
        for (int i = 0; i < LW; i++) begin
            axi_bus.rdata_i       = base + 32'(i);
            axi_bus.rdata_valid_i = 1'b1;
            tick();
        end
        axi_bus.rdata_valid_i = 1'b0;
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    logic [31:0] exp_arb [4];

    initial begin
        axi_bus.rdata_i       = 32'd0;
        axi_bus.rdata_valid_i = 1'b0;
        axi_bus.wdata_resp_i  = 1'b0;
`ifdef CACHE_AXI_RR_ARB_EN
        exp_arb = '{32'h6000_0000, 32'h5000_0000, 32'h6000_0000, 32'h5000_0000};
`else
        exp_arb = '{32'h6000_0000, 32'h6000_0000, 32'h6000_0000, 32'h6000_0000};
`endif
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_val("rst_rrdy", {127'd0, dev_rrdy_o}, 128'd1);
        check_val("rst_wrdy", {127'd0, dev_wrdy_o}, 128'd1);
        check_val("rst_ren", {127'd0, axi_bus.axi_ren_o}, 128'd0);
        check_val("rst_wen", {127'd0, axi_bus.axi_wen_o}, 128'd0);
        check_val("rst_irdata", inst_rdata_o, 128'd0);
        check_val("rst_pulses", {124'd0, inst_rvalid_o, data_rvalid_o, unc_rvalid_o, data_bvalid_o}, 128'd0);

        // icache fill, unaligned miss address
        inst_ren_i = 1'b1; inst_araddr_i = 32'h1C00_0034;
        tick();
        inst_ren_i = 1'b0;
        check_val("i_raddr", {96'd0, axi_bus.axi_raddr_o}, 128'h1C00_0030);
        check_val("i_rlen", {120'd0, axi_bus.axi_rlen_o}, 128'd3);
        check_val("i_rrdy_busy", {127'd0, dev_rrdy_o}, 128'd0);
        for (int i = 0; i < LW; i++) begin
            check_val("i_no_early_pulse", {127'd0, inst_rvalid_o}, 128'd0);
            axi_bus.rdata_i = 32'hA0 + 32'(i); axi_bus.rdata_valid_i = 1'b1;
            tick();
        end
        axi_bus.rdata_valid_i = 1'b0;
        check_val("i_rvalid", {127'd0, inst_rvalid_o}, 128'd1);
        check_val("i_rdata", inst_rdata_o, line_of(32'hA0));
        tick();
        check_val("i_rvalid_once", {127'd0, inst_rvalid_o}, 128'd0);

        // uncached read beats a simultaneous dcache fill
        unc_ren_i = 1'b1; unc_raddr_i = 32'h2000_0004;
        data_ren_i = 1'b1; data_araddr_i = 32'h3000_001C;
        tick();
        unc_ren_i = 1'b0;
        check_val("u_raddr", {96'd0, axi_bus.axi_raddr_o}, 128'h2000_0004);
        check_val("u_rlen", {120'd0, axi_bus.axi_rlen_o}, 128'd0);
        axi_bus.rdata_i = 32'h5555_AAAA; axi_bus.rdata_valid_i = 1'b1;
        tick();
        axi_bus.rdata_valid_i = 1'b0;
        check_val("u_rvalid", {127'd0, unc_rvalid_o}, 128'd1);
        check_val("u_rdata", {96'd0, unc_rdata_o}, 128'h5555_AAAA);
        tick();
        data_ren_i = 1'b0;
        check_val("d_raddr", {96'd0, axi_bus.axi_raddr_o}, 128'h3000_0010);
        check_val("d_rlen", {120'd0, axi_bus.axi_rlen_o}, 128'd3);
        feed_line(32'hB0);
        check_val("d_rvalid", {127'd0, data_rvalid_o}, 128'd1);
        check_val("d_rdata", data_rdata_o, line_of(32'hB0));
        tick();

        // writeback in flight blocks a same-line fill, other fills still go
        data_wen_i = 1'b1; data_awaddr_i = 32'h8000_0040;
        data_wdata_i = {32'hCC03, 32'hCC02, 32'hCC01, 32'hCC00};
        tick();
        data_wen_i = 1'b0; data_awaddr_i = 32'd0; data_wdata_i = 128'd0;
        check_val("wb_waddr", {96'd0, axi_bus.axi_waddr_o}, 128'h8000_0040);
        check_val("wb_wlen", {120'd0, axi_bus.axi_wlen_o}, 128'd3);
        check_val("wb_wsel", {124'd0, axi_bus.axi_wsel_o}, 128'hF);
        data_ren_i = 1'b1; data_araddr_i = 32'h8000_0048;
        tick();
        check_val("haz_block", {127'd0, axi_bus.axi_ren_o}, 128'd0);
        inst_ren_i = 1'b1; inst_araddr_i = 32'h9000_0000;
        tick();
        inst_ren_i = 1'b0;
        check_val("haz_other_ren", {127'd0, axi_bus.axi_ren_o}, 128'd1);
        check_val("haz_other_addr", {96'd0, axi_bus.axi_raddr_o}, 128'h9000_0000);
        for (int i = 0; i < LW; i++) begin
            check_val("wb_wdata", {96'd0, axi_bus.axi_wdata_o}, {96'd0, 32'hCC00 + 32'(i)});
            check_val("wb_wlast", {127'd0, axi_bus.axi_wlast_o}, {127'd0, i == LW - 1});
            check_val("wb_no_early_b", {127'd0, data_bvalid_o}, 128'd0);
            axi_bus.wdata_resp_i = 1'b1;
            tick();
        end
        axi_bus.wdata_resp_i = 1'b0;
        check_val("wb_bvalid", {127'd0, data_bvalid_o}, 128'd1);
        check_val("wb_wrdy", {127'd0, dev_wrdy_o}, 128'd1);
        feed_line(32'hC0);
        check_val("haz_i_rdata", inst_rdata_o, line_of(32'hC0));
        tick();
        data_ren_i = 1'b0;
        check_val("haz_d_after", {96'd0, axi_bus.axi_raddr_o}, 128'h8000_0040);
        feed_line(32'hD0);
        check_val("haz_d_rdata", data_rdata_o, line_of(32'hD0));
        tick();

        // uncached write, inputs dropped right after acceptance
        unc_wen_i = 4'b0011; unc_waddr_i = 32'h4000_0008; unc_wdata_i = 32'hDEAD_BEEF;
        tick();
        unc_wen_i = 4'd0; unc_waddr_i = 32'd0; unc_wdata_i = 32'd0;
        check_val("uw_wsel", {124'd0, axi_bus.axi_wsel_o}, 128'h3);
        check_val("uw_wdata", {96'd0, axi_bus.axi_wdata_o}, 128'hDEAD_BEEF);
        check_val("uw_wlast", {127'd0, axi_bus.axi_wlast_o}, 128'd1);
        check_val("uw_waddr", {96'd0, axi_bus.axi_waddr_o}, 128'h4000_0008);
        check_val("uw_wlen", {120'd0, axi_bus.axi_wlen_o}, 128'd0);
        axi_bus.wdata_resp_i = 1'b1;
        tick();
        axi_bus.wdata_resp_i = 1'b0;
        check_val("uw_bvalid", {127'd0, unc_bvalid_o}, 128'd1);
        check_val("uw_wen_off", {127'd0, axi_bus.axi_wen_o}, 128'd0);
        tick();
        check_val("uw_bvalid_once", {127'd0, unc_bvalid_o}, 128'd0);

        // reset in the middle of a fill
        inst_ren_i = 1'b1; inst_araddr_i = 32'h1C00_0100;
        tick();
        inst_ren_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_bus.rdata_i = 32'hE0 + 32'(i); axi_bus.rdata_valid_i = 1'b1;
            tick();
        end
        axi_bus.rdata_valid_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mrst_rrdy", {127'd0, dev_rrdy_o}, 128'd1);
        check_val("mrst_no_pulse", {127'd0, inst_rvalid_o}, 128'd0);
        check_val("mrst_rdata", inst_rdata_o, 128'd0);
        tick();
        check_val("mrst_no_pulse2", {127'd0, inst_rvalid_o}, 128'd0);
        inst_ren_i = 1'b1; inst_araddr_i = 32'h1C00_0200;
        tick();
        inst_ren_i = 1'b0;
        feed_line(32'hF0);
        check_val("mrst_refill", inst_rdata_o, line_of(32'hF0));
        check_val("mrst_refill_v", {127'd0, inst_rvalid_o}, 128'd1);
        tick();

        // icache and dcache held together
        inst_ren_i = 1'b1; inst_araddr_i = 32'h5000_0000;
        data_ren_i = 1'b1; data_araddr_i = 32'h6000_0000;
        for (int g = 0; g < 4; g++) begin
            wait_ren();
            check_val("arb_order", {96'd0, axi_bus.axi_raddr_o}, {96'd0, exp_arb[g]});
            feed_line(32'h100 * 32'(g + 1));
            if (g == 3) begin
                inst_ren_i = 1'b0;
                data_ren_i = 1'b0;
            end
        end
        tick();
        check_val("arb_idle", {127'd0, dev_rrdy_o}, 128'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
Name: cache_axi_bridge

Overview:
- Parametrised bridge between the L1 caches (icache line fill, dcache line fill/writeback, dcache uncached word access) and the single-ID AXI master interface.
- Independent read and write FSMs, with a configurable line size.
- Accepted writes are latched internally, so the requester may change its inputs after acceptance.
- A read-after-write hazard guard stops a line fill from bypassing an in-flight writeback to the same line.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line; power of two, 2..16.
- ADDR_W, 32, address width.
- OFFS_W, $clog2(LINE_WORDS)+2, derived; byte-offset bits of a line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- inst_ren_i  in  1  icache fill request (level)
- inst_araddr_i  in  ADDR_W  icache miss address
- inst_rvalid_o  out  1  one-cycle fill-done pulse
- inst_rdata_o  out  32*LINE_WORDS  icache fill line
- data_ren_i  in  1  dcache fill request
- data_araddr_i  in  ADDR_W  dcache miss address
- data_rvalid_o  out  1  fill-done pulse
- data_rdata_o  out  32*LINE_WORDS  dcache fill line
- data_wen_i  in  1  dcache line writeback request
- data_awaddr_i  in  ADDR_W  writeback address
- data_wdata_i  in  32*LINE_WORDS  writeback line
- data_bvalid_o  out  1  writeback-done pulse
- unc_ren_i  in  1  uncached read request
- unc_raddr_i  in  ADDR_W  uncached read address
- unc_rvalid_o  out  1  uncached read-done pulse
- unc_rdata_o  out  32  uncached read data
- unc_wen_i  in  4  uncached byte strobes; nonzero means request
- unc_waddr_i  in  ADDR_W  uncached write address
- unc_wdata_i  in  32  uncached write data
- unc_bvalid_o  out  1  uncached write-done pulse
- dev_rrdy_o  out  1  read FSM idle
- dev_wrdy_o  out  1  write FSM idle
- axi_ren_o  out  1  read request active
- axi_raddr_o  out  ADDR_W  read address
- axi_rlen_o  out  8  read beats minus one
- rdata_i  in  32  read beat data
- rdata_valid_i  in  1  read beat valid
- axi_wen_o  out  1  write request active
- axi_waddr_o  out  ADDR_W  write address
- axi_wlen_o  out  8  write beats minus one
- axi_wsel_o  out  4  write strobes
- axi_wdata_o  out  32  current beat data
- axi_wlast_o  out  1  last write beat
- wdata_resp_i  in  1  write beat accepted

Behaviour:
- Reset: both FSMs IDLE, counters 0, every pulse output 0, rdata outputs 0, latched write regs 0. Reset mid-burst aborts silently and no done pulse is emitted.
- Read FSM states: R_IDLE, R_ICACHE, R_DCACHE, R_UNC.
  - Grant in R_IDLE, in priority order unc > dcache > icache. The chosen address is latched at grant.
  - Line address is {addr[ADDR_W-1:OFFS_W], 0}; rlen = LINE_WORDS-1.
  - R_UNC uses the exact address and rlen = 0.
  - axi_ren_o = (state != R_IDLE).
- Read beats: each rdata_valid_i writes word[rcnt] of the line buffer and increments rcnt.
  - When rcnt == LINE_WORDS-1 with valid: return to R_IDLE and pulse the matching rvalid on the next cycle.
  - R_UNC: the first valid captures unc_rdata_o, pulses unc_rvalid_o next cycle, returns to R_IDLE.
  - inst_rdata_o and data_rdata_o are separate buffers, each held until that requester's next fill.
- Write FSM states: W_IDLE, W_LINE, W_UNC.
  - unc_wen_i != 0 beats data_wen_i in arbitration.
  - Address, data and strobes are latched at acceptance.
  - W_LINE: wsel = 4'hF, wlen = LINE_WORDS-1, axi_wdata_o = latched word[wcnt].
  - wdata_resp_i increments wcnt; axi_wlast_o = W_LINE && wcnt == LINE_WORDS-1.
  - On the final response: return to W_IDLE and pulse data_bvalid_o next cycle.
  - W_UNC: single beat with latched strobes; wlast = 1; on response, unc_bvalid_o pulses next cycle.
- Hazard: a cached read request whose line address equals the latched W_LINE address is not granted while the write FSM is busy. Other requests may still be granted.
- Simultaneous events: a read grant and a write acceptance in the same cycle are both taken. A new request is evaluated on the cycle after the done pulse's source state returns to IDLE.

Optional Feature:
- CACHE_AXI_RR_ARB_EN: icache and dcache fills arbitrate round-robin, tracked by a last-granted bit updated at grant; uncached reads keep absolute priority.
- Without the macro: fixed priority, dcache over icache.

Decomposition:
- Package cache_axi_pkg holds:
  - read and write state enums;
  - LINE_WORDS default;
  - the line-address helper function.
- Sub-module: cache_axi_rd_arb, the grant logic including the hazard mask and the optional round-robin pointer.

Test Plan:
- icache fill at 0x1C00_0034, beats 0xA0..0xA3 → axi_raddr 0x1C00_0030, rlen 3; inst_rdata_o = {A3,A2,A1,A0}; one inst_rvalid_o pulse.
- unc_ren and data_ren in the same cycle → R_UNC first, rlen 0, then the dcache fill. Both done pulses occur with correct data.
- Writeback to 0x8000_0040 in flight plus data_ren to 0x8000_0048 → read held until data_bvalid_o; an icache read to 0x9000_0000 is granted meanwhile.
- Uncached write, strobes 4'b0011, data 0xDEAD_BEEF; inputs cleared after accept → wsel 0011, wdata DEADBEEF, wlast 1, unc_bvalid_o pulse.
- rst asserted after 2 of 4 read beats → dev_rrdy_o = 1 next cycle, no rvalid pulse, next fill has rcnt starting at 0.
- With CACHE_AXI_RR_ARB_EN, icache and dcache requests held continuously → grants alternate D, I, D, I.
